// File: rtl/ripple_pkg.sv
// Shared definitions for the bit-serial ripple adder and subtractor datapaths.
package ripple_pkg;

  // Handshake/sequencing states common to both serial arithmetic blocks.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned MIN_WIDTH = 1;
  localparam int unsigned MAX_WIDTH = 32;

  // Width of a bit counter that must represent 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - b_in with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = a ^ b ^ b_in;
  // Borrow when the minuend bit is smaller, or bits are equal and a borrow arrives.
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: LSB-first through one full-subtractor cell,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor
  import ripple_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .b_in  (borrow),
    .d     (cell_d),
    .b_out (cell_bout)
  );

  // Result register fills from the MSB side so the first (LSB) bit ends at bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = cell_d;
    end else begin : g_res_wn
      assign res_next = {cell_d, res[WIDTH-1:1]};
    end
  endgenerate

  // Sequencer, operand/result shift registers, borrow flop and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      cnt       <= '0;
      borrow    <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            borrow   <= b_in;
            cnt      <= '0;
            res      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          res    <= res_next;
          a_sh   <= a_sh >> 1'b1;
          b_sh   <= b_sh >> 1'b1;
          borrow <= cell_bout;
          if (cnt == LAST_BIT) begin
            // Final bit: publish result and borrow, counter holds at terminal.
            diff      <= res_next;
            b_out     <= cell_bout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor with borrow-in/borrow-out. It is the subtract-direction counterpart of the ripple-carry adder datapath. It accepts a WIDTH-bit operand pair over a valid/ready handshake and computes the difference LSB-first, one bit per clock, through a single one-bit full-subtractor cell and a borrow flop. It presents the result on a second valid/ready handshake, giving an area-minimal alternative to a parallel ripple subtractor.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  minuend (unsigned).
- b  in  WIDTH  subtrahend (unsigned).
- b_in  in  1  borrow-in.
- out_valid  out  1  result present; high only in DONE.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  difference.
- b_out  out  1  borrow-out.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready:
  - capture a and b into shift registers;
  - load the borrow flop with b_in;
  - clear the bit counter;
  - go to RUN.
- RUN: each cycle, feed the operand LSBs and the borrow flop into the cell. Then:
  - shift the cell's difference bit into the MSB of the result register;
  - shift the operand registers right;
  - load the borrow flop with the cell's borrow-out;
  - increment the counter.
  - After the WIDTH-th bit, go to DONE.
- DONE: out_valid=1; diff = result register; b_out = borrow flop. On out_ready, go to IDLE.
- Arithmetic:
  - diff = (a − b − b_in) mod 2^WIDTH;
  - b_out = 1 iff a < b + b_in (unsigned compare, WIDTH+1-bit);
  - equivalently {b_out,diff} satisfies a − b − b_in = diff − b_out·2^WIDTH.
- Cell equations:
  - d = a ^ b ^ bin;
  - bout = (~a & b) | (~(a ^ b) & bin).
- Operands are sampled only at the accept edge; later changes on a/b/b_in have no effect.
- in_valid while not IDLE is ignored; no queuing.
- out_ready while not DONE is ignored.
- diff and b_out remain stable while out_valid && !out_ready.

## Timing
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, diff=0, b_out=0, counter=0, borrow flop=0.
- Reset is asynchronous. Asserting it mid-RUN or in DONE aborts the operation immediately. No out_valid is produced for the aborted operation.
- Latency:
  - accept edge = edge 0;
  - RUN occupies edges 1..WIDTH;
  - out_valid is high from just after edge WIDTH.
- Handshake completion:
  - DONE→IDLE occurs on the edge where out_ready=1.
  - in_ready rises the following cycle.
  - There is no same-cycle out→in bypass.
- Minimum issue interval: WIDTH+2 cycles.
- WIDTH=1: one RUN cycle; behaves as a registered full subtractor with handshakes.
- Counter width: $clog2(WIDTH+1). Terminal count is WIDTH−1 in RUN, with no wrap-around beyond it.

## Structure
- Shared package ripple_pkg holds the state typedef (enum logic [1:0] {IDLE, RUN, DONE}). The same package serves both the adder and subtractor blocks.
- Sub-module full_subtractor holds the combinational one-bit cell (ports a, b, b_in, d, b_out). It is instantiated once and is unit-testable on its own, mirroring full_adder.
- Top-level serial_subtractor contains the FSM, shift registers, counter, and borrow flop.

## Test plan
- Reset: hold rst for 3 cycles → in_ready=1, out_valid=0, diff=8'h00, b_out=0.
- Basic: a=8'h5A, b=8'h23, b_in=0 → diff=8'h37, b_out=0. out_valid rises exactly 8 cycles after the accept edge.
- Borrow ripple: a=8'h00, b=8'h01, b_in=0 → diff=8'hFF, b_out=1. Also a=8'h10, b=8'h10, b_in=1 → diff=8'hFF, b_out=1.
- Backpressure:
  - hold out_ready=0 for 5 cycles in DONE → diff and b_out stable, out_valid held;
  - pulse in_valid with new operands during RUN → ignored; result still matches the first operands.
- Reset mid-operation: assert rst on the 4th RUN cycle → out_valid never rises. The next operation, a=8'hFF, b=8'h01, b_in=1, gives diff=8'hFD, b_out=0.
- Exhaustive at WIDTH=4: all 512 combinations of (a,b,b_in), back-to-back with out_ready=1. Check each against the model {b_out,diff} = {a<b+b_in, (a−b−b_in)&4'hF}, with $error on any mismatch.
